// File: rtl/dvsd_mac_acc.sv
// Sequential multiply-accumulate back end for the dvsd_8216m1 product bus.
// Define DVSD_MAC_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module dvsd_mac_acc #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf,
   output logic             busy
);

   // state  | meaning
   // S_IDLE | waiting for start
   // S_ACC  | accepting product beats until remaining reaches zero
   // S_HOLD | presenting result until out_ready
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   remaining;
   logic               ovf;
   logic [ACC_W:0]     sum;
   logic [ACC_W-1:0]   acc_nxt;
   logic               ovf_nxt;

   always_comb begin
      sum = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};
`ifdef DVSD_MAC_ACC_SATURATE_EN
      acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_nxt = sum[ACC_W-1:0];
`endif
      ovf_nxt = ovf | sum[ACC_W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         acc       <= '0;
         remaining <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc       <= '0;
                  ovf       <= 1'b0;
                  remaining <= len;
                  busy      <= 1'b1;
                  if (len == '0) begin
                     state     <= S_HOLD;
                     out_valid <= 1'b1;
                     out_data  <= '0;
                     out_ovf   <= 1'b0;
                  end else begin
                     state    <= S_ACC;
                     in_ready <= 1'b1;
                  end
               end
            end
            S_ACC: begin
               if (in_valid) begin
                  acc       <= acc_nxt;
                  ovf       <= ovf_nxt;
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state     <= S_HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_data  <= acc_nxt;
                     out_ovf   <= ovf_nxt;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dvsd_mac_acc.sv
// Self-checking bench for dvsd_mac_acc: directed cases plus randomized transactions
// compared every cycle against a transaction-level sum model.
module tb_dvsd_mac_acc;
   localparam int AW = 17;
   localparam int CW = 8;
   localparam longint unsigned MOD = 64'd1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] len = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   prod = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] out_data;
   logic          out_ovf;
   logic          busy;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   dvsd_mac_acc #(.ACC_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: 0 = waiting, 1 = collecting beats, 2 = presenting result.
   int              m_mode = 0;
   int              m_need = 0;
   longint unsigned m_total = 0;
   longint unsigned m_data = 0;
   bit              m_ovf = 1'b0;

   function automatic longint unsigned final_sum(input longint unsigned t);
`ifdef DVSD_MAC_ACC_SATURATE_EN
      return (t >= MOD) ? MOD - 1 : t;
`else
      return t % MOD;
`endif
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode = 0; m_need = 0; m_total = 0; m_data = 0; m_ovf = 1'b0;
      end else begin
         case (m_mode)
            0: if (start) begin
               m_total = 0;
               m_need  = int'(len);
               if (len == 0) begin
                  m_mode = 2; m_data = 0; m_ovf = 1'b0;
               end else m_mode = 1;
            end
            1: if (in_valid) begin
               m_total += longint'(prod);
               m_need--;
               if (m_need == 0) begin
                  m_mode = 2;
                  m_data = final_sum(m_total);
                  m_ovf  = (m_total >= MOD);
               end
            end
            default: if (out_ready) m_mode = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, m_mode == 1);
         chk("out_valid", out_valid, m_mode == 2);
         chk("busy", busy, m_mode != 0);
         if (m_mode == 2) begin
            chk("out_data", out_data, m_data);
            chk("out_ovf", out_ovf, m_ovf);
         end
      end
   end

   task automatic drive(input bit st, input int l, input bit v, input int p, input bit ordy);
      @(negedge clk);
      start = st; len = CW'(l); in_valid = v; prod = 16'(p); out_ready = ordy;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // basic sum 10+20+30
      drive(1, 3, 0, 0, 0);
      drive(0, 0, 1, 10, 0);
      chk("basic_busy", busy, 1);
      drive(0, 0, 1, 20, 0);
      drive(0, 0, 1, 30, 0);
      drive(0, 0, 0, 0, 1);
      chk("basic_valid", out_valid, 1);
      chk("basic_data", out_data, 60);
      chk("basic_ovf", out_ovf, 0);
      drive(0, 0, 0, 0, 0);
      chk("basic_idle", busy, 0);

      // gaps and backpressure
      drive(1, 2, 0, 0, 0);
      drive(0, 0, 1, 65025, 0);
      repeat (3) drive(0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0);
         chk("bp_data", out_data, 65026);
         chk("bp_valid", out_valid, 1);
      end
      drive(0, 0, 0, 0, 1);
      chk("bp_data_last", out_data, 65026);
      drive(0, 0, 0, 0, 0);
      chk("bp_idle", busy, 0);

      // zero length, then start during HOLD ignored
      drive(1, 0, 0, 0, 0);
      drive(1, 5, 0, 0, 0);
      chk("zero_valid", out_valid, 1);
      chk("zero_data", out_data, 0);
      drive(0, 0, 0, 0, 1);
      chk("zero_still_hold", out_valid, 1);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      chk("zero_no_acc", in_ready, 0);
      chk("zero_no_busy", busy, 0);

      // overflow with three large products
      drive(1, 3, 0, 0, 0);
      repeat (3) drive(0, 0, 1, 65025, 0);
      drive(0, 0, 0, 0, 1);
`ifdef DVSD_MAC_ACC_SATURATE_EN
      chk("ovf_data", out_data, 131071);
`else
      chk("ovf_data", out_data, 64003);
`endif
      chk("ovf_flag", out_ovf, 1);
      drive(0, 0, 0, 0, 0);

      // reset mid-operation
      drive(1, 4, 0, 0, 0);
      drive(0, 0, 1, 500, 0);
      drive(0, 0, 1, 600, 0);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1; prod = 16'd99;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_busy", busy, 0);
      drive(1, 1, 0, 0, 0);
      drive(0, 0, 1, 7, 0);
      drive(0, 0, 0, 0, 1);
      chk("fresh_data", out_data, 7);
      chk("fresh_ovf", out_ovf, 0);
      drive(0, 0, 0, 0, 0);

      // randomized transactions
      for (int t = 0; t < 60; t++) begin
         int cyc;
         drive(1, $urandom_range(0, 6), 0, 0, 0);
         cyc = 0;
         forever begin
            @(negedge clk);
            if (m_mode == 0) break;
            if (cyc >= 200) begin
               chk("rand_timeout", m_mode, 0);
               break;
            end
            cyc++;
            start     = ($urandom_range(0, 4) == 0);
            len       = CW'($urandom_range(0, 255));
            in_valid  = ($urandom_range(0, 3) != 0);
            prod      = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(60000, 65535))
                                                    : 16'($urandom_range(0, 65535));
            out_ready = ($urandom_range(0, 2) == 0);
         end
         start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
